fir_error_accum: RTL and testbench
==================================

# fir_error_accum

Downstream evaluation stage for the approximate FIR filter: consumes the 16-bit signed output of the approximate filter alongside the exact-arithmetic filter output, sample by sample, and accumulates error metrics over a fixed window. Results are the fitness figures the grammatical-evolution flow reads back per individual: sum of absolute error, mean absolute error, worst-case error, mismatch count and index of first mismatch. One measurement runs per `start` pulse. Results hold until the next measurement begins.

## Interface
- `WINDOW`, 32: samples accumulated per measurement; power of two, 2..256.
- `WARMUP`, 3: valid samples discarded after start (filter delay-line fill); 0..15.
- `ACC_W`, 24: width of the saturating SAE accumulator; ≥ 16 + log2(WINDOW) recommended.

- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state and outputs.
- `start`, in, 1: begin a measurement; honoured only in IDLE or DONE.
- `in_valid`, in, 1: sample pair valid this cycle.
- `approx_sample`, in, 16: signed output of the approximate filter.
- `exact_sample`, in, 16: signed output of the exact filter.
- `busy`, out, 1: high in WARMUP, ACCUM and DRAIN.
- `done`, out, 1: one-cycle pulse when the results become valid.
- `sae`, out, ACC_W: unsigned sum of |approx − exact|, saturating.
- `mae`, out, ACC_W: `sae >> log2(WINDOW)`.
- `max_err`, out, 16: unsigned maximum |approx − exact|.
- `mismatch_cnt`, out, 9: count of samples with nonzero error.
- `first_mm_idx`, out, 8: window index of first nonzero error; 8'hFF if none.

## Operation
- FSM states: IDLE → (start) WARMUP → ACCUM → DRAIN → DONE → IDLE.
- If `WARMUP == 0`, start goes directly to ACCUM.
- IDLE: `in_valid` is ignored.
- WARMUP: counts valid samples and discards them. After the `WARMUP`-th valid sample, moves to ACCUM.
- ACCUM: each valid sample is accepted and given window index 0..WINDOW−1. After index WINDOW−1 is accepted, moves to DRAIN.
- Invalid cycles (gaps) are tolerated in WARMUP and ACCUM; counters hold.
- DRAIN: one cycle, flushes the abs-diff pipeline register. Then DONE: `done`=1 for exactly that cycle, then IDLE.
- Start accepted in IDLE or DONE clears all result registers on the next edge (`first_mm_idx` ← 8'hFF). Start in WARMUP, ACCUM or DRAIN is ignored.
- Arithmetic:
  - diff = sign-extended 17-bit approx − exact.
  - abs = |diff|, range 0..65535, fits 16 bits unsigned.
  - `sae` saturates at 2^ACC_W − 1 and never wraps.
  - `max_err` is updated when abs > current value.
  - `mismatch_cnt` increments when abs ≠ 0.
  - `first_mm_idx` latches the index of the first abs ≠ 0 only.
- Reset mid-measurement: state ← IDLE, all outputs 0 except `first_mm_idx` ← 8'hFF; `done` does not fire.

## Timing
- Stage 1 registers abs and the window index from the accepted sample. Stage 2 updates the accumulators.
- Results reflect sample k two edges after sample k is accepted.
- `done` rises two cycles after the edge accepting window index WINDOW−1: DRAIN, then DONE.
- Result outputs are stable from `done` until the edge after the next accepted start.
- Reset values: `busy`=0, `done`=0, `sae`=0, `mae`=0, `max_err`=0, `mismatch_cnt`=0, `first_mm_idx`=8'hFF.
- Start and `in_valid` in the same cycle in IDLE: the sample is not counted. Counting begins the following cycle.

## Structure
- Shared package `fir_eval_pkg`:
  - state enum `eval_state_t` (IDLE, WARMUP, ACCUM, DRAIN, DONE);
  - `SAMPLE_W`=16;
  - `NO_MISMATCH`=8'hFF.
- Sub-module `abs_diff16`: combinational 16-bit signed difference to 16-bit unsigned magnitude. It is reused by other evaluation blocks.
- FSM, counters and accumulators live in `fir_error_accum` itself.

## Test plan
- Identical streams: approx = exact = 32 sample pairs, WINDOW=32, WARMUP=3 → `sae`=0, `max_err`=0, `mismatch_cnt`=0, `first_mm_idx`=8'hFF; `done` pulses once, two cycles after the last accepted sample.
- Constant offset: approx = exact + 5 on every sample → `sae`=160, `mae`=5, `max_err`=5, `mismatch_cnt`=32, `first_mm_idx`=0.
- Extremes, single error: one pair approx=32767, exact=−32768 at index 10, all others equal → `max_err`=65535, `sae`=65535, `mismatch_cnt`=1, `first_mm_idx`=10.
- Saturation with ACC_W=17: all 32 pairs differ by 65535 → `sae`=131071, held; no wrap.
- Gaps and ignored start: `in_valid` toggles 1/0, start re-pulsed mid-ACCUM → same results as the gap-free run; index and counters unaffected by the extra start.
- Reset mid-ACCUM at index 15 → `busy`=0 and `first_mm_idx`=8'hFF immediately, all other outputs 0 immediately; no `done`; a fresh start then completes normally.

Source files
------------

// File: rtl/fir_eval_pkg.sv
// Shared types and constants for the FIR evaluation blocks.
// Contents: evaluation FSM state enum, sample width, "no mismatch" index marker.
// No logic; imported by abs_diff16 and fir_error_accum.
package fir_eval_pkg;

    localparam int         SAMPLE_W    = 16;
    localparam logic [7:0] NO_MISMATCH = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } eval_state_t;

endpackage

// File: rtl/abs_diff16.sv
// Signed 16-bit difference to unsigned 16-bit magnitude, purely combinational.
// Ports: i_a, i_b signed samples in; o_abs = |i_a - i_b| out (0..65535).
// Zero latency, no flow control.
module abs_diff16
    import fir_eval_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_a,
    input  logic [SAMPLE_W-1:0] i_b,
    output logic [SAMPLE_W-1:0] o_abs
);

    logic signed [SAMPLE_W:0] w_diff;
    logic signed [SAMPLE_W:0] w_neg;

    // One extra bit keeps the full -65535..65535 range; the magnitude then
    // always fits back into SAMPLE_W unsigned bits.
    assign w_diff = $signed({i_a[SAMPLE_W-1], i_a}) - $signed({i_b[SAMPLE_W-1], i_b});
    assign w_neg  = -w_diff;
    assign o_abs  = w_diff[SAMPLE_W] ? w_neg[SAMPLE_W-1:0] : w_diff[SAMPLE_W-1:0];

endmodule

// File: rtl/fir_error_accum.sv
// Error-metric accumulator comparing approximate vs exact FIR output over a window.
// Ports: clk/reset, i_start, i_in_valid + sample pair in; o_busy, o_done, o_sae,
//        o_mae, o_max_err, o_mismatch_cnt, o_first_mm_idx out (held until next start).
// Latency: results reflect a sample two edges after acceptance; no backpressure.
module fir_error_accum
    import fir_eval_pkg::*;
#(
    parameter int WINDOW = 32,
    parameter int WARMUP = 3,
    parameter int ACC_W  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic                i_in_valid,
    input  logic [SAMPLE_W-1:0] i_approx_sample,
    input  logic [SAMPLE_W-1:0] i_exact_sample,
    output logic                o_busy,
    output logic                o_done,
    output logic [ACC_W-1:0]    o_sae,
    output logic [ACC_W-1:0]    o_mae,
    output logic [SAMPLE_W-1:0] o_max_err,
    output logic [8:0]          o_mismatch_cnt,
    output logic [7:0]          o_first_mm_idx
);

    localparam int          LOG2W     = $clog2(WINDOW);
    localparam logic [7:0]  IDX_LAST  = 8'(WINDOW - 1);
    // Only used when WARMUP > 0; the WARMUP state is never entered otherwise.
    localparam logic [3:0]  WARM_LAST = 4'(WARMUP - 1);
    localparam eval_state_t START_ST  = (WARMUP == 0) ? ST_ACCUM : ST_WARMUP;

    eval_state_t         r_state;
    logic [3:0]          r_warm_cnt;
    logic [7:0]          r_idx;

    logic                r_s1_vld;
    logic [SAMPLE_W-1:0] r_s1_abs;
    logic [7:0]          r_s1_idx;

    logic [ACC_W-1:0]    r_sae;
    logic [SAMPLE_W-1:0] r_max;
    logic [8:0]          r_cnt;
    logic [7:0]          r_first;

    logic [SAMPLE_W-1:0] w_abs;
    logic                w_start_ok;
    logic                w_accept;
    logic [ACC_W:0]      w_sae_sum;

    abs_diff16 u_abs (
        .i_a   (i_approx_sample),
        .i_b   (i_exact_sample),
        .o_abs (w_abs)
    );

    assign w_start_ok = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept   = (r_state == ST_ACCUM) && i_in_valid;
    // Extra carry bit detects overflow so the accumulator can clamp instead of wrapping.
    assign w_sae_sum  = {1'b0, r_sae} + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, r_s1_abs};

    // Control FSM and sample counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_warm_cnt <= '0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state    <= START_ST;
                        r_warm_cnt <= '0;
                        r_idx      <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WARMUP: begin
                    if (i_in_valid) begin
                        if (r_warm_cnt == WARM_LAST) r_state <= ST_ACCUM;
                        else                         r_warm_cnt <= r_warm_cnt + 4'd1;
                    end
                end
                ST_ACCUM: begin
                    if (i_in_valid) begin
                        if (r_idx == IDX_LAST) r_state <= ST_DRAIN;
                        else                   r_idx   <= r_idx + 8'd1;
                    end
                end
                ST_DRAIN: r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: register magnitude and window index of the accepted sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_abs <= '0;
            r_s1_idx <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_abs <= w_abs;
                r_s1_idx <= r_idx;
            end
        end
    end

    // Stage 2: accumulators. A zero mismatch count means no mismatch has been
    // latched yet, which avoids confusing a real index 255 with the marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sae   <= '0;
            r_max   <= '0;
            r_cnt   <= '0;
            r_first <= NO_MISMATCH;
        end else if (w_start_ok) begin
            r_sae   <= '0;
            r_max   <= '0;
            r_cnt   <= '0;
            r_first <= NO_MISMATCH;
        end else if (r_s1_vld) begin
            r_sae <= w_sae_sum[ACC_W] ? {ACC_W{1'b1}} : w_sae_sum[ACC_W-1:0];
            if (r_s1_abs > r_max) r_max <= r_s1_abs;
            if (r_s1_abs != '0) begin
                r_cnt <= r_cnt + 9'd1;
                if (r_cnt == '0) r_first <= r_s1_idx;
            end
        end
    end

    assign o_busy         = (r_state == ST_WARMUP) || (r_state == ST_ACCUM) || (r_state == ST_DRAIN);
    assign o_done         = (r_state == ST_DONE);
    assign o_sae          = r_sae;
    assign o_mae          = r_sae >> LOG2W;
    assign o_max_err      = r_max;
    assign o_mismatch_cnt = r_cnt;
    assign o_first_mm_idx = r_first;

endmodule

// File: tb/tb_fir_error_accum.sv
// Randomized directed bench for fir_error_accum: two instances (ACC_W 24 and 17)
// share one stimulus stream; expected metrics come from a window-level model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_fir_error_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [15:0] approx_s;
    logic [15:0] exact_s;

    logic        a_busy, a_done, b_busy, b_done;
    logic [23:0] a_sae, a_mae;
    logic [16:0] b_sae, b_mae;
    logic [15:0] a_max, b_max;
    logic [8:0]  a_cnt, b_cnt;
    logic [7:0]  a_first, b_first;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] ap[32];
    logic signed [15:0] ex[32];

    always #5 clk = ~clk;

    fir_error_accum #(.WINDOW(32), .WARMUP(3), .ACC_W(24)) dut_a (
        .clk(clk), .reset(reset), .i_start(start), .i_in_valid(in_valid),
        .i_approx_sample(approx_s), .i_exact_sample(exact_s),
        .o_busy(a_busy), .o_done(a_done), .o_sae(a_sae), .o_mae(a_mae),
        .o_max_err(a_max), .o_mismatch_cnt(a_cnt), .o_first_mm_idx(a_first)
    );

    fir_error_accum #(.WINDOW(32), .WARMUP(3), .ACC_W(17)) dut_b (
        .clk(clk), .reset(reset), .i_start(start), .i_in_valid(in_valid),
        .i_approx_sample(approx_s), .i_exact_sample(exact_s),
        .o_busy(b_busy), .o_done(b_done), .o_sae(b_sae), .o_mae(b_mae),
        .o_max_err(b_max), .o_mismatch_cnt(b_cnt), .o_first_mm_idx(b_first)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window-level reference: plain integer arithmetic over the stored pairs.
    task automatic model(input int accw, output logic [31:0] sae, output logic [31:0] mae,
                         output logic [31:0] mx, output logic [31:0] cnt, output logic [31:0] first);
        longint sum = 0;
        longint lim;
        int     m = 0;
        int     c = 0;
        int     f = 255;
        for (int i = 0; i < 32; i++) begin
            int d = int'(ap[i]) - int'(ex[i]);
            int a = (d < 0) ? -d : d;
            sum += a;
            if (a > m) m = a;
            if (a != 0) begin
                if (c == 0) f = i;
                c++;
            end
        end
        lim = (longint'(1) << accw) - 1;
        if (sum > lim) sum = lim;
        sae   = 32'(sum);
        mae   = 32'(sum / 32);
        mx    = 32'(m);
        cnt   = 32'(c);
        first = 32'(f);
    endtask

    task automatic check_results(input string tag);
        logic [31:0] s, m, x, c, f;
        model(24, s, m, x, c, f);
        chk({tag, ".a.sae"},   {8'd0, a_sae},   s);
        chk({tag, ".a.mae"},   {8'd0, a_mae},   m);
        chk({tag, ".a.max"},   {16'd0, a_max},  x);
        chk({tag, ".a.cnt"},   {23'd0, a_cnt},  c);
        chk({tag, ".a.first"}, {24'd0, a_first}, f);
        model(17, s, m, x, c, f);
        chk({tag, ".b.sae"},   {15'd0, b_sae},  s);
        chk({tag, ".b.mae"},   {15'd0, b_mae},  m);
        chk({tag, ".b.max"},   {16'd0, b_max},  x);
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        approx_s = 16'($urandom);
        exact_s  = 16'($urandom);
    endtask

    // One measurement. Called and returns on a falling edge.
    task automatic run(input string tag, input bit gaps, input bit extra_start, input int abort_at);
        int dcount;
        // A sample presented with start must not count towards warmup.
        start    = 1'b1;
        in_valid = 1'b1;
        approx_s = 16'($urandom);
        exact_s  = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_after_start"}, {31'd0, a_busy}, 32'd1);
        chk({tag, ".sae_cleared"},      {8'd0, a_sae},   32'd0);
        chk({tag, ".first_cleared"},    {24'd0, a_first}, 32'hFF);
        // Warmup samples carry large random errors; counting any of them would show.
        for (int w = 0; w < 3; w++) begin
            if (gaps) begin
                drive_idle();
                @(negedge clk);
            end
            in_valid = 1'b1;
            approx_s = 16'($urandom);
            exact_s  = 16'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < 32; i++) begin
            if (gaps && (i % 2 == 1)) begin
                drive_idle();
                @(negedge clk);
            end
            in_valid = 1'b1;
            approx_s = ap[i];
            exact_s  = ex[i];
            if (extra_start && i == 16) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (i == abort_at) begin
                drive_idle();
                chk({tag, ".first_before_reset"}, {24'd0, a_first}, 32'd2);
                reset = 1'b1;
                #1;
                chk({tag, ".rst.busy"},  {31'd0, a_busy}, 32'd0);
                chk({tag, ".rst.first"}, {24'd0, a_first}, 32'hFF);
                chk({tag, ".rst.sae"},   {8'd0, a_sae},   32'd0);
                chk({tag, ".rst.max"},   {16'd0, a_max},  32'd0);
                chk({tag, ".rst.cnt"},   {23'd0, a_cnt},  32'd0);
                chk({tag, ".rst.b_sae"}, {15'd0, b_sae},  32'd0);
                @(negedge clk);
                reset  = 1'b0;
                dcount = 0;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (a_done || b_done || a_busy) dcount++;
                end
                chk({tag, ".no_done_after_reset"}, 32'(dcount), 32'd0);
                return;
            end
        end
        drive_idle();
        chk({tag, ".drain.done"}, {31'd0, a_done}, 32'd0);
        chk({tag, ".drain.busy"}, {31'd0, a_busy}, 32'd1);
        @(negedge clk);
        chk({tag, ".done"},      {31'd0, a_done}, 32'd1);
        chk({tag, ".b_done"},    {31'd0, b_done}, 32'd1);
        chk({tag, ".done.busy"}, {31'd0, a_busy}, 32'd0);
        check_results(tag);
        @(negedge clk);
        chk({tag, ".done_pulse_end"}, {31'd0, a_done}, 32'd0);
        check_results({tag, ".held"});
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        approx_s = '0;
        exact_s  = '0;
        repeat (2) @(negedge clk);
        chk("reset.busy",  {31'd0, a_busy},  32'd0);
        chk("reset.done",  {31'd0, a_done},  32'd0);
        chk("reset.sae",   {8'd0, a_sae},    32'd0);
        chk("reset.mae",   {8'd0, a_mae},    32'd0);
        chk("reset.max",   {16'd0, a_max},   32'd0);
        chk("reset.cnt",   {23'd0, a_cnt},   32'd0);
        chk("reset.first", {24'd0, a_first}, 32'hFF);
        reset = 1'b0;

        // Valid samples in IDLE are ignored.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            approx_s = 16'($urandom);
            exact_s  = 16'($urandom);
            @(negedge clk);
        end
        drive_idle();
        chk("idle.busy", {31'd0, a_busy}, 32'd0);
        chk("idle.cnt",  {23'd0, a_cnt},  32'd0);

        // Identical streams.
        for (int i = 0; i < 32; i++) begin
            ap[i] = 16'($urandom);
            ex[i] = ap[i];
        end
        run("ident", 1'b0, 1'b0, -1);

        // Constant offset of +5.
        for (int i = 0; i < 32; i++) begin
            ex[i] = 16'($urandom_range(0, 30000));
            ap[i] = ex[i] + 16'sd5;
        end
        run("offset", 1'b0, 1'b0, -1);

        // Single extreme error at index 10.
        for (int i = 0; i < 32; i++) begin
            ap[i] = 16'($urandom);
            ex[i] = ap[i];
        end
        ap[10] = 16'sh7FFF;
        ex[10] = 16'sh8000;
        run("extreme", 1'b0, 1'b0, -1);

        // Every pair at maximum distance: saturates the 17-bit accumulator.
        for (int i = 0; i < 32; i++) begin
            ap[i] = (i % 2 == 0) ? 16'sh7FFF : 16'sh8000;
            ex[i] = (i % 2 == 0) ? 16'sh8000 : 16'sh7FFF;
        end
        run("saturate", 1'b0, 1'b0, -1);
        chk("saturate.b_sae_max", {15'd0, b_sae}, 32'd131071);

        // Sparse random errors with gaps and a spurious start mid-window.
        for (int i = 0; i < 32; i++) begin
            ex[i] = 16'($urandom);
            ap[i] = ($urandom_range(0, 3) == 0) ? ex[i] + 16'($urandom_range(1, 900)) : ex[i];
        end
        run("gaps", 1'b1, 1'b1, -1);

        // Fully random pairs.
        for (int i = 0; i < 32; i++) begin
            ap[i] = 16'($urandom);
            ex[i] = 16'($urandom);
        end
        run("random", 1'b0, 1'b0, -1);

        // Reset after window index 15, then a fresh measurement.
        for (int i = 0; i < 32; i++) begin
            ex[i] = 16'($urandom);
            ap[i] = ($urandom_range(0, 1) == 0) ? ex[i] : ex[i] - 16'($urandom_range(1, 50));
        end
        ap[0] = ex[0];
        ap[1] = ex[1];
        ap[2] = ex[2] ^ 16'h0001;
        run("abort", 1'b0, 1'b0, 15);
        run("fresh", 1'b1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
